ysyx_23060236_axi_sram_slave: RTL

- AXI4-subset slave (responder) backed by an internal word-addressed SRAM array.
- Terminates the master-side bus that the core and MMU path drive, for simulation and bring-up without the external SoC.
- Serves one transaction at a time: single-beat or burst reads and writes, with byte strobes, ID echo and SLVERR on out-of-range addresses.

---
 rtl/ysyx_23060236_axi_sram_slave.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060236_axi_sram_slave.sv
// AXI4-subset slave backed by a word-addressed SRAM. It serves one transaction at a time,
// supports bursts and byte strobes, and returns SLVERR for out-of-range addresses.
module ysyx_23060236_axi_sram_slave #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [31:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] LIMIT  = 33'(BASE) + 33'(DEPTH) * 33'd4;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_DATA, WR_RESP} state_t;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (33'(a) < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    state_t         state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [7:0]     beat_q, beat_d;
    logic [7:0]     len_q, len_d;
    logic [31:0]    addr_q, addr_d;
    logic [2:0]     size_q, size_d;
    logic [1:0]     burst_q, burst_d;
    logic [3:0]     id_q, id_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     rresp_q, rresp_d;
    logic           mem_we;

    logic [31:0] adv_addr;
    logic        cur_ok, adv_ok;
    logic [31:0] cur_word, adv_word;
    logic        last_beat;

    // FIXED keeps the address; INCR and the reserved encodings step by the beat size
    assign adv_addr  = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);
    assign cur_ok    = in_range(addr_q);
    assign adv_ok    = in_range(adv_addr);
    assign cur_word  = cur_ok ? mem[word_idx(addr_q)] : 32'd0;
    assign adv_word  = adv_ok ? mem[word_idx(adv_addr)] : 32'd0;
    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        len_d   = len_q;
        addr_d  = addr_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_slave_arvalid) begin
                    addr_d  = io_slave_araddr;
                    id_d    = io_slave_arid;
                    len_d   = io_slave_arlen;
                    size_d  = io_slave_arsize;
                    burst_d = io_slave_arburst;
                    beat_d  = 8'd0;
                    lat_d   = LAT_W'(LATENCY - 1);
                    state_d = RD_WAIT;
                end else if (io_slave_awvalid) begin
                    addr_d  = io_slave_awaddr;
                    id_d    = io_slave_awid;
                    len_d   = io_slave_awlen;
                    size_d  = io_slave_awsize;
                    burst_d = io_slave_awburst;
                    beat_d  = 8'd0;
                    state_d = WR_DATA;
                end
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    rdata_d = cur_word;
                    rresp_d = cur_ok ? OKAY : SLVERR;
                    state_d = RD_BEAT;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RD_BEAT: begin
                if (io_slave_rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = adv_addr;
                        rdata_d = adv_word;
                        rresp_d = adv_ok ? OKAY : SLVERR;
                    end
                end
            end
            WR_DATA: begin
                if (io_slave_wvalid) begin
                    mem_we = cur_ok;
                    // sticky error: out-of-range beat or wlast disagreeing with the beat count
                    if (!cur_ok || (io_slave_wlast != last_beat)) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = adv_addr;
                    end
                end
            end
            WR_RESP: begin
                if (io_slave_bready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_q   <= '0;
            beat_q  <= 8'd0;
            len_q   <= 8'd0;
            addr_q  <= 32'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            id_q    <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            rresp_q <= 2'd0;
        end else begin
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    // SRAM contents survive reset; only a live, in-range W beat modifies them
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (io_slave_wstrb[b]) mem[word_idx(addr_q)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
            end
        end
    end

    assign io_slave_arready = (state_q == IDLE) && !reset;
    assign io_slave_awready = (state_q == IDLE) && !reset && !io_slave_arvalid;
    assign io_slave_wready  = (state_q == WR_DATA);
    assign io_slave_bvalid  = (state_q == WR_RESP);
    assign io_slave_bresp   = (io_slave_bvalid && err_q) ? SLVERR : OKAY;
    assign io_slave_bid     = id_q;
    assign io_slave_rvalid  = (state_q == RD_BEAT);
    assign io_slave_rdata   = rdata_q;
    assign io_slave_rresp   = rresp_q;
    assign io_slave_rlast   = io_slave_rvalid && last_beat;
    assign io_slave_rid     = id_q;

endmodule
